// File: rtl/inst_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM state encoding
// and byte-per-word helpers.
package inst_loader_pkg;

   // Loader FSM states.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Bytes per instruction word for the default 32-bit instruction width.
   localparam int DATA_WIDTH_DEFAULT = 32;
   localparam int BPW                = DATA_WIDTH_DEFAULT / 8;

   // Bytes per word for an arbitrary (multiple-of-8) word width.
   function automatic int bytes_per_word(input int data_width);
      return data_width / 8;
   endfunction

   // Width of a counter that indexes the bytes of a word (at least 1 bit).
   function automatic int byte_cnt_width(input int bpw);
      return (bpw > 1) ? $clog2(bpw) : 1;
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs an incoming byte stream little-endian into DATA_WIDTH words.
// Byte k of a word lands in bits [8k+7:8k]. word_full flags the cycle in
// which the last byte of a word is being accepted.
module word_assembler
   import inst_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clear,
   input  logic                  accept,
   input  logic [7:0]            byte_data,
   output logic [DATA_WIDTH-1:0] word,
   output logic                  word_full
);

   localparam int            NB   = bytes_per_word(DATA_WIDTH);
   localparam int            CW   = byte_cnt_width(NB);
   localparam logic [CW-1:0] LAST = CW'(NB - 1);

   logic [CW-1:0] byte_cnt;

   // Last byte of the word is on the bus and being taken this cycle.
   assign word_full = accept && (byte_cnt == LAST);

   // Byte lane register and position counter; clear drops any partial word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_cnt <= '0;
         word     <= '0;
      end else if (clear) begin
         byte_cnt <= '0;
         word     <= '0;
      end else if (accept) begin
         word[8*byte_cnt +: 8] <= byte_data;
         byte_cnt              <= word_full ? '0 : byte_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/inst_mem_loader.sv
// Write-side companion of the instruction memory. Receives program bytes
// over a valid/ready handshake, packs them into words and writes them to
// consecutive RAM addresses from 0, holding the CPU until the load is done.
//
// Handshake: a byte transfers on a rising clk edge where byte_valid and
// byte_ready are both 1. byte_ready depends only on the FSM state (RECV),
// never on byte_valid. The sender must hold byte_data stable while
// byte_valid is 1 and the transfer has not happened yet.
module inst_mem_loader
   import inst_loader_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   word_count,
   input  logic                  abort,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  busy,
   output logic                  done,
   output logic                  cpu_hold
);

   // Number of words in the RAM, expressed on the wider count bus.
   localparam logic [ADDR_WIDTH:0] RAM_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};

   state_t                  state;
   state_t                  next_state;
   logic [ADDR_WIDTH:0]     cnt;
   logic [ADDR_WIDTH:0]     idx;
   logic [ADDR_WIDTH:0]     idx_next;
   logic [ADDR_WIDTH:0]     wc_sat;
   logic                    accept;
   logic                    asm_clear;
   logic                    word_full;
   logic [DATA_WIDTH-1:0]   asm_word;

   // Requested count clipped to the RAM size so a load never wraps.
   assign wc_sat   = (word_count > RAM_WORDS) ? RAM_WORDS : word_count;
   assign idx_next = idx + 1'b1;
   assign accept   = byte_valid && byte_ready;

   word_assembler #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_asm (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (asm_clear),
      .accept    (accept),
      .byte_data (byte_data),
      .word      (asm_word),
      .word_full (word_full)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and output decode; abort overrides a pending write.
   always_comb begin
      next_state = state;
      byte_ready = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_wdata  = '0;
      busy       = 1'b0;
      done       = 1'b0;
      asm_clear  = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               asm_clear  = 1'b1;
               next_state = (wc_sat == '0) ? DONE : RECV;
            end
         end
         RECV: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (abort) begin
               asm_clear  = 1'b1;
               next_state = IDLE;
            end else if (word_full) begin
               next_state = WRITE;
            end
         end
         WRITE: begin
            busy      = 1'b1;
            mem_addr  = idx[ADDR_WIDTH-1:0];
            mem_wdata = asm_word;
            if (abort) begin
               asm_clear  = 1'b1;
               next_state = IDLE;
            end else begin
               mem_we     = 1'b1;
               next_state = (idx_next == cnt) ? DONE : RECV;
            end
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
      endcase
   end

   // Word count, word index and CPU hold; hold drops as the FSM enters DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt      <= '0;
         idx      <= '0;
         cpu_hold <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  cnt <= wc_sat;
                  idx <= '0;
                  if (wc_sat == '0) begin
                     cpu_hold <= 1'b0;
                  end else begin
                     cpu_hold <= 1'b1;
                  end
               end
            end
            RECV: begin
               if (abort) begin
                  idx <= '0;
               end
            end
            WRITE: begin
               if (abort) begin
                  idx <= '0;
               end else begin
                  idx <= idx_next;
                  if (idx_next == cnt) begin
                     cpu_hold <= 1'b0;
                  end
               end
            end
            DONE: begin
               idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed testbench for inst_mem_loader: normal loads, stalled stream,
// empty load, full and oversized loads, reset and abort mid-load.
module tb_inst_mem_loader;

   localparam int DW = 32;
   localparam int AW = 6;
   localparam int W  = AW + DW;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [AW:0]   word_count;
   logic          abort;
   logic          byte_valid;
   logic [7:0]    byte_data;
   logic          byte_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          busy;
   logic          done;
   logic          cpu_hold;

   int            n_checks   = 0;
   int            n_fail     = 0;
   int            cyc        = 0;
   int            last_acc   = 0;
   int            last_we    = 0;
   int            done_cyc   = 0;
   int            we_count   = 0;
   int            done_count = 0;
   logic          hold_at_done = 1'b1;
   logic [W-1:0]  exp_q[$];

   inst_mem_loader #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .word_count (word_count),
      .abort      (abort),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .busy       (busy),
      .done       (done),
      .cpu_hold   (cpu_hold)
   );

   // Clock and cycle counter.
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Hard stop if something hangs.
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Single comparison point.
   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Scoreboard: every write is matched against the expected queue.
   always @(negedge clk) begin
      logic [W-1:0] e;
      if (rst_n) begin
         if (byte_valid && byte_ready) last_acc = cyc;
         if (mem_we) begin
            we_count++;
            last_we = cyc;
            if (exp_q.size() == 0) begin
               check("unexpected_we", {32'd0, mem_addr, 26'd0}, 64'hdead);
            end else begin
               e = exp_q.pop_front();
               check("wr_addr", 64'(mem_addr), 64'(e[W-1:DW]));
               check("wr_data", 64'(mem_wdata), 64'(e[DW-1:0]));
            end
         end
         if (done) begin
            done_count++;
            done_cyc     = cyc;
            hold_at_done = cpu_hold;
         end
      end
   end

   // Driver: pulse start for one cycle.
   task automatic do_start(input int count);
      start      = 1'b1;
      word_count = (AW+1)'(count);
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Driver: offer one byte and hold it until accepted (bounded).
   task automatic send_byte(input logic [7:0] b);
      bit ok = 1'b0;
      byte_valid = 1'b1;
      byte_data  = b;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (byte_ready) begin
            @(posedge clk);
            #1;
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check("byte_accept_timeout", 0, 1);
   endtask

   // Word pattern used by the bulk loads.
   function automatic logic [DW-1:0] pattern(input int w, input int seed);
      return (DW'(w) * 32'h01010101) ^ DW'(seed);
   endfunction

   // Driver: stream n words; optional idle cycle after every byte.
   task automatic load_words(input int n, input int seed, input bit toggle);
      logic [DW-1:0] wd;
      for (int w = 0; w < n; w++) begin
         wd = pattern(w, seed);
         exp_q.push_back({AW'(w), wd});
         for (int k = 0; k < DW/8; k++) begin
            send_byte(wd[8*k +: 8]);
            if (toggle) begin
               byte_valid = 1'b0;
               @(posedge clk);
               #1;
            end
         end
      end
      byte_valid = 1'b0;
   endtask

   // Wait for a done pulse, bounded in cycles.
   task automatic wait_done(input int max_cyc, input string tag);
      int dc0 = done_count;
      for (int i = 0; i < max_cyc; i++) begin
         @(posedge clk);
         #1;
         if (done_count != dc0) return;
      end
      check(tag, 0, 1);
   endtask

   // The two-word program from the bring-up notes.
   task automatic load_two(input bit toggle);
      logic [7:0] prog [8];
      prog = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h20, 8'h00};
      exp_q.push_back({6'd0, 32'h00100013});
      exp_q.push_back({6'd1, 32'h00200093});
      do_start(2);
      for (int i = 0; i < 8; i++) begin
         send_byte(prog[i]);
         if (toggle) begin
            byte_valid = 1'b0;
            @(posedge clk);
            #1;
         end
      end
      byte_valid = 1'b0;
   endtask

   initial begin
      int dc0;
      int we0;
      rst_n      = 1'b0;
      start      = 1'b0;
      word_count = '0;
      abort      = 1'b0;
      byte_valid = 1'b0;
      byte_data  = '0;

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst_cpu_hold", 64'(cpu_hold), 1);
      check("rst_byte_ready", 64'(byte_ready), 0);
      check("rst_mem_we", 64'(mem_we), 0);
      check("rst_busy", 64'(busy), 0);
      check("rst_done", 64'(done), 0);
      check("rst_mem_addr", 64'(mem_addr), 0);
      check("rst_mem_wdata", 64'(mem_wdata), 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Two-word load, continuous stream.
      dc0 = done_count;
      load_two(1'b0);
      @(negedge clk);
      check("busy_in_write", 64'(busy), 1);
      check("hold_in_write", 64'(cpu_hold), 1);
      wait_done(10, "done_timeout_two");
      check("we_latency", 64'(last_we - last_acc), 1);
      check("done_latency", 64'(done_cyc - last_acc), 2);
      check("hold_at_done", 64'(hold_at_done), 0);
      check("done_count_two", 64'(done_count - dc0), 1);
      check("exp_empty_two", 64'(exp_q.size()), 0);
      @(negedge clk);
      check("hold_idle_after", 64'(cpu_hold), 0);
      check("ready_idle_after", 64'(byte_ready), 0);

      // Same load with byte_valid toggling.
      we0 = we_count;
      load_two(1'b1);
      wait_done(10, "done_timeout_toggle");
      check("we_count_toggle", 64'(we_count - we0), 2);
      check("exp_empty_toggle", 64'(exp_q.size()), 0);

      // Empty load.
      we0 = we_count;
      dc0 = done_count;
      do_start(0);
      @(negedge clk);
      check("zero_done", 64'(done), 1);
      check("zero_hold", 64'(cpu_hold), 0);
      check("zero_busy", 64'(busy), 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      check("zero_done_pulse", 64'(done), 0);
      check("zero_no_we", 64'(we_count - we0), 0);
      check("zero_done_count", 64'(done_count - dc0), 1);

      // Full RAM, then an oversized request that must saturate.
      for (int r = 0; r < 2; r++) begin
         we0 = we_count;
         do_start(r == 0 ? 64 : 100);
         load_words(64, 32'h5a00c3e1 + r, 1'b0);
         wait_done(10, "done_timeout_full");
         check("full_we_count", 64'(we_count - we0), 64);
         check("full_done_after_last", 64'(done_cyc - last_we), 1);
         check("full_exp_empty", 64'(exp_q.size()), 0);
      end
      // Bytes offered in IDLE are refused.
      we0 = we_count;
      byte_valid = 1'b1;
      byte_data  = 8'hff;
      @(negedge clk);
      check("idle_ready", 64'(byte_ready), 0);
      repeat (3) @(posedge clk);
      #1;
      byte_valid = 1'b0;
      check("idle_no_we", 64'(we_count - we0), 0);

      // Reset in the middle of a load.
      do_start(2);
      for (int i = 0; i < 3; i++) send_byte(8'(i + 1));
      byte_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      check("midrst_hold", 64'(cpu_hold), 1);
      check("midrst_busy", 64'(busy), 0);
      check("midrst_ready", 64'(byte_ready), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Abort after six bytes of a three-word load.
      dc0 = done_count;
      we0 = we_count;
      do_start(3);
      load_words(1, 32'h11223344, 1'b0);
      send_byte(8'haa);
      send_byte(8'hbb);
      byte_valid = 1'b0;
      abort      = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(busy), 0);
      check("abort_hold", 64'(cpu_hold), 1);
      check("abort_ready", 64'(byte_ready), 0);
      repeat (5) @(posedge clk);
      #1;
      check("abort_no_done", 64'(done_count - dc0), 0);
      check("abort_we_count", 64'(we_count - we0), 1);
      check("abort_exp_empty", 64'(exp_q.size()), 0);

      // Reload a single word over address 0.
      do_start(1);
      load_words(1, 32'hcafe0000, 1'b0);
      wait_done(10, "done_timeout_reload");
      check("reload_exp_empty", 64'(exp_q.size()), 0);
      check("reload_hold", 64'(hold_at_done), 0);

      // Abort landing on the write cycle suppresses the write.
      dc0 = done_count;
      we0 = we_count;
      do_start(1);
      for (int k = 0; k < 4; k++) send_byte(8'h40 + 8'(k));
      byte_valid = 1'b0;
      abort      = 1'b1;
      @(negedge clk);
      check("abort_write_we", 64'(mem_we), 0);
      @(posedge clk);
      #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_write_busy", 64'(busy), 0);
      check("abort_write_hold", 64'(cpu_hold), 1);
      repeat (4) @(posedge clk);
      #1;
      check("abort_write_no_done", 64'(done_count - dc0), 0);
      check("abort_write_no_we", 64'(we_count - we0), 0);

      check("final_exp_empty", 64'(exp_q.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
